// File: rtl/grey2rgb.sv
// rtl/grey2rgb.sv - 2-stage grey-to-RGB stream pipeline with line/frame counters; HEATMAP_EN selects pseudo-colour
module grey2rgb #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input  logic        axi_clk,
   input  logic        axi_reset_n,
   input  logic        i_grey_data_valid,
   input  logic [7:0]  i_grey_data,
   output logic        o_grey_data_ready,
   output logic        o_rgb_data_valid,
   output logic [23:0] o_rgb_data,
   input  logic        i_rgb_ready,
   output logic        o_rgb_last,
   output logic        o_frame_done
);

   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   logic             rstDone;
   logic             s1Valid;
   logic [7:0]       s1Data;
   logic             s2Valid;
   logic [23:0]      s2Data;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             frameDone;

   logic s1Ready;
   logic s2Ready;
   logic inFire;
   logic outFire;
   logic colEnd;
   logic rowEnd;

   function automatic logic [23:0] colourMap(input logic [7:0] g);
`ifdef HEATMAP_EN
      logic [7:0] r;
      logic [7:0] gr;
      logic [7:0] b;
      r  = g[7] ? {g[6:0], 1'b0}  : 8'h00;
      gr = g[7] ? {~g[6:0], 1'b0} : {g[6:0], 1'b0};
      b  = g[7] ? 8'h00           : {~g[6:0], 1'b0};
      return {b, gr, r};
`else
      return {g, g, g};
`endif
   endfunction

   assign s2Ready = ~s2Valid | i_rgb_ready;
   assign s1Ready = ~s1Valid | s2Ready;
   // rstDone keeps ready low while reset is held and for the release edge itself
   assign o_grey_data_ready = rstDone & s1Ready;
   assign inFire  = i_grey_data_valid & o_grey_data_ready;
   assign outFire = s2Valid & i_rgb_ready;
   assign colEnd  = (col == COL_W'(IMG_WIDTH - 1));
   assign rowEnd  = (row == ROW_W'(IMG_HEIGHT - 1));

   assign o_rgb_data_valid = s2Valid;
   assign o_rgb_data       = s2Data;
   assign o_rgb_last       = s2Valid & colEnd;
   assign o_frame_done     = frameDone;

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         rstDone   <= 1'b0;
         s1Valid   <= 1'b0;
         s1Data    <= 8'h00;
         s2Valid   <= 1'b0;
         s2Data    <= 24'h000000;
         col       <= '0;
         row       <= '0;
         frameDone <= 1'b0;
      end else begin
         rstDone <= 1'b1;
         if (s1Ready) s1Valid <= inFire;
         if (inFire) s1Data <= i_grey_data;
         if (s2Ready) s2Valid <= s1Valid;
         if (s1Valid && s2Ready) s2Data <= colourMap(s1Data);
         frameDone <= outFire & colEnd & rowEnd;
         if (outFire) begin
            if (colEnd) begin
               col <= '0;
               row <= rowEnd ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_grey2rgb.sv
// tb/tb_grey2rgb.sv - self-checking bench for grey2rgb: small-frame and full-size instances on shared stimulus
`timescale 1ns/1ps
module tb_grey2rgb;

   localparam int SW = 4;
   localparam int SH = 2;
   localparam int BW = 512;
   localparam int BH = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstN;
   logic        gValid;
   logic [7:0]  gData;
   logic        rgbReady;
   logic        readyA, validA, lastA, doneA;
   logic [23:0] dataA;
   logic        readyB, validB, lastB, doneB;
   logic [23:0] dataB;

   grey2rgb #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dutA (
      .axi_clk(clk), .axi_reset_n(rstN),
      .i_grey_data_valid(gValid), .i_grey_data(gData), .o_grey_data_ready(readyA),
      .o_rgb_data_valid(validA), .o_rgb_data(dataA), .i_rgb_ready(rgbReady),
      .o_rgb_last(lastA), .o_frame_done(doneA)
   );

   grey2rgb dutB (
      .axi_clk(clk), .axi_reset_n(rstN),
      .i_grey_data_valid(gValid), .i_grey_data(gData), .o_grey_data_ready(readyB),
      .o_rgb_data_valid(validB), .o_rgb_data(dataB), .i_rgb_ready(rgbReady),
      .o_rgb_last(lastB), .o_frame_done(doneB)
   );

   int errors = 0;
   int checks = 0;

   logic [23:0] expQ[$];
   int          outCntA, outCntB;
   logic        pendDoneA, pendDoneB;
   logic        stallPrev;
   logic [23:0] heldA, heldB;
   logic        heldLastA;

   logic        sValid, sReady, sLastA, sDoneA, sInFire, sOutFire;
   logic [23:0] sDataB;

   typedef struct {
      logic [7:0]  g;
      logic [23:0] rgb;
   } vec_t;
   vec_t vecs[5];

   // Reference colour map from plain arithmetic on the grey level
   function automatic logic [23:0] refMap(input int g);
      int r, gr, b;
`ifdef HEATMAP_EN
      if (g < 128) begin
         r = 0; gr = 2 * g; b = 2 * (127 - g);
      end else begin
         r = 2 * (g - 128); gr = 2 * (255 - g); b = 0;
      end
`else
      r = g; gr = g; b = g;
`endif
      return {b[7:0], gr[7:0], r[7:0]};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // One clock: drive, sample #1 later, score against the model, advance to next negedge
   task automatic cycle(input logic v, input logic [7:0] d, input logic r);
      logic [23:0] e;
      gValid = v; gData = d; rgbReady = r;
      #1;
      sValid = validB; sReady = readyB; sDataB = dataB; sLastA = lastA; sDoneA = doneA;
      check("doneA", doneA, pendDoneA);
      check("doneB", doneB, pendDoneB);
      check("readyA", readyA, (expQ.size() < 2) || r);
      check("readyB", readyB, (expQ.size() < 2) || r);
      if (expQ.size() == 0) check("idleValidB", validB, 0);
      if (!validB) check("idleLastB", lastB, 0);
      if (stallPrev) begin
         check("holdValid", validB, 1);
         check("holdDataA", dataA, heldA);
         check("holdDataB", dataB, heldB);
         check("holdLastA", lastA, heldLastA);
      end
      sInFire  = v & readyB;
      sOutFire = validB & r;
      pendDoneA = 1'b0;
      pendDoneB = 1'b0;
      if (sOutFire) begin
         if (expQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL spuriousOut: actual=%0h required=none", dataB);
         end else begin
            e = expQ.pop_front();
            check("validA", validA, 1);
            check("dataA", dataA, e);
            check("dataB", dataB, e);
            check("lastA", lastA, (outCntA % SW) == SW - 1);
            check("lastB", lastB, (outCntB % BW) == BW - 1);
         end
         pendDoneA = (outCntA % (SW * SH)) == SW * SH - 1;
         pendDoneB = (outCntB % (BW * BH)) == BW * BH - 1;
         outCntA++;
         outCntB++;
      end
      if (sInFire) expQ.push_back(refMap(int'(d)));
      stallPrev = validB & ~r;
      heldA = dataA; heldB = dataB; heldLastA = lastA;
      @(negedge clk);
   endtask

   task automatic doReset();
      #2;
      rstN = 1'b0; gValid = 1'b0; rgbReady = 1'b0;
      #1;
      check("rstReadyA", readyA, 0);
      check("rstReadyB", readyB, 0);
      check("rstValidA", validA, 0);
      check("rstValidB", validB, 0);
      check("rstDataB", dataB, 0);
      check("rstLastA", lastA, 0);
      check("rstDoneA", doneA, 0);
      check("rstDoneB", doneB, 0);
      expQ.delete();
      outCntA = 0; outCntB = 0;
      pendDoneA = 1'b0; pendDoneB = 1'b0; stallPrev = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      check("relReadyB", readyB, 1);
      check("relValidB", validB, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int idx, first, lastC, outN, lastMask, doneCnt, doneAt, pix8At, sent;
      bit got;
      logic [7:0] t3[4];
      logic [23:0] outs[$];
      logic v, r;
      logic [7:0] d;

      rstN = 1'b0; gValid = 1'b0; gData = 8'h00; rgbReady = 1'b0;
      @(negedge clk);
      doReset();

      // Reset asserted with both stages full
      cycle(1'b1, 8'h11, 1'b0);
      cycle(1'b1, 8'h22, 1'b0);
      cycle(1'b1, 8'h33, 1'b0);
      check("t1Full", sReady, 0);
      doReset();
      for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1);

      // Single pixel latency
      cycle(1'b1, 8'h5A, 1'b1);
      check("t2InFire", sInFire, 1);
      cycle(1'b0, 8'h00, 1'b1);
      check("t2Lat1", sValid, 0);
      cycle(1'b0, 8'h00, 1'b1);
      check("t2Lat2", sValid, 1);
`ifdef HEATMAP_EN
      check("t2Data", sDataB, 24'h4AB400);
`else
      check("t2Data", sDataB, 24'h5A5A5A);
`endif
      cycle(1'b0, 8'h00, 1'b1);
      check("t2OneCycle", sValid, 0);

      // Colour map table
`ifdef HEATMAP_EN
      vecs[0] = '{8'h00, 24'hFE0000};
      vecs[1] = '{8'h7F, 24'h00FE00};
      vecs[2] = '{8'h80, 24'h00FE00};
      vecs[3] = '{8'hFF, 24'h0000FE};
      vecs[4] = '{8'h5A, 24'h4AB400};
`else
      vecs[0] = '{8'h00, 24'h000000};
      vecs[1] = '{8'h7F, 24'h7F7F7F};
      vecs[2] = '{8'h80, 24'h808080};
      vecs[3] = '{8'hFF, 24'hFFFFFF};
      vecs[4] = '{8'h5A, 24'h5A5A5A};
`endif
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, vecs[i].g, 1'b1);
         got = 1'b0;
         for (int k = 0; k < 4 && !got; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (sValid) begin
               got = 1'b1;
               check("mapTable", sDataB, vecs[i].rgb);
            end
         end
         if (!got) begin
            checks++; errors++;
            $display("FAIL mapTimeout: actual=none required=%0h", vecs[i].rgb);
         end
      end

      // Backpressure: 5 stalled clocks, then drain
      t3[0] = 8'h01; t3[1] = 8'h02; t3[2] = 8'h03; t3[3] = 8'h04;
      idx = 0;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, t3[idx], 1'b0);
         if (sInFire) idx++;
      end
      check("t3Buffered", idx, 2);
      check("t3ReadyLow", sReady, 0);
      check("t3Hold", sDataB, refMap(1));
      outs.delete();
      first = -1; lastC = -1;
      for (int k = 0; k < 12; k++) begin
         v = (idx < 4);
         cycle(v, v ? t3[idx] : 8'h00, 1'b1);
         if (sInFire) idx++;
         if (sOutFire) begin
            outs.push_back(sDataB);
            if (first < 0) first = k;
            lastC = k;
         end
      end
      check("t3Count", outs.size(), 4);
      for (int k = 0; k < 4 && k < outs.size(); k++) check("t3Order", outs[k], refMap(k + 1));
      check("t3NoGap", lastC - first, 3);

      // Line/frame marking on the 4x2 instance
      doReset();
      sent = 0; outN = 0; lastMask = 0; doneCnt = 0; doneAt = -1; pix8At = -1;
      for (int k = 0; k < 14; k++) begin
         v = (sent < 9);
         cycle(v, 8'(8'h10 + sent), 1'b1);
         if (sInFire) sent++;
         if (sDoneA) begin
            doneCnt++;
            doneAt = k;
         end
         if (sOutFire) begin
            outN++;
            if (sLastA) lastMask = lastMask | (1 << outN);
            if (outN == 8) pix8At = k;
         end
      end
      check("t4Outputs", outN, 9);
      check("t4LastMask", lastMask, (1 << 4) | (1 << 8));
      check("t4DoneCount", doneCnt, 1);
      check("t4DoneAt", doneAt, pix8At + 1);

      // Random valid/ready against the scoreboard
      sent = 0;
      for (int k = 0; k < 20000 && (sent < 1000 || expQ.size() != 0); k++) begin
         v = (sent < 1000) && ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         d = 8'($urandom_range(0, 255));
         cycle(v, d, r);
         if (sInFire) sent++;
      end
      check("t6Sent", sent, 1000);
      check("t6Drained", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
